// File: rtl/mac_rr_scheduler_if.sv
// Sample-stream request side and packet-result side of the round-robin square-accumulate scheduler.
// slave = scheduler view, master = producer/consumer view.
interface mac_rr_scheduler_if #(
  parameter int NREQ = 2,
  parameter int DW   = 8,
  parameter int FW   = 20
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;

  logic               out_valid;
  logic               out_ready;
  logic [FW-1:0]      out_f;
  logic [IW-1:0]      out_id;
  logic [7:0]         out_count;
  logic               out_ovf;

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_f, out_id, out_count, out_ovf
  );

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_f, out_id, out_count, out_ovf
  );
endinterface

// File: rtl/mac_rr_scheduler.sv
// Round-robin packet scheduler over one f += a*a datapath; result valid 2 edges after the last beat.
// Granted requester sees ready only while BUSY; a held result blocks all new grants until out_ready.
module mac_rr_scheduler #(
  parameter int NREQ = 2,
  parameter int DW   = 8,
  parameter int FW   = 20
) (
  input  logic                clk,
  input  logic                reset,
  mac_rr_scheduler_if.slave   bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [FW-1:0]   acc_q, acc_d;
  logic [2*DW-1:0] sq_q, sq_d;
  logic            sq_vld_q, sq_vld_d;
  logic [7:0]      count_q, count_d;
  logic            ovf_q, ovf_d;

  logic            out_vld_q, out_vld_d;
  logic [FW-1:0]   out_f_q, out_f_d;
  logic [IW-1:0]   out_id_q, out_id_d;
  logic [7:0]      out_count_q, out_count_d;
  logic            out_ovf_q, out_ovf_d;

  logic            any_vld;
  logic [IW-1:0]   winner;
  logic [IW:0]     idx_w;
  logic [NREQ-1:0] req_ready_c;
  logic [DW-1:0]   a_sel;
  logic [2*DW-1:0] a_ext;
  logic [FW:0]     sum;

  // Scan from the far end toward ptr so the nearest valid requester is the last one written.
  always_comb begin
    any_vld = 1'b0;
    winner  = ptr_q;
    idx_w   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx_w = {1'b0, ptr_q} + (IW + 1)'(i);
      if (idx_w >= (IW + 1)'(NREQ)) idx_w = idx_w - (IW + 1)'(NREQ);
      if (bus.req_valid[idx_w[IW-1:0]]) begin
        any_vld = 1'b1;
        winner  = idx_w[IW-1:0];
      end
    end
  end

  assign a_sel = bus.req_data[gnt_q*DW +: DW];
  assign a_ext = {{DW{1'b0}}, a_sel};
  assign sum   = {1'b0, acc_q} + {{(FW + 1 - 2*DW){1'b0}}, sq_q};

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    acc_d       = acc_q;
    sq_d        = sq_q;
    sq_vld_d    = sq_vld_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_vld_d   = out_vld_q;
    out_f_d     = out_f_q;
    out_id_d    = out_id_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    req_ready_c = '0;

    // The square registered on the previous beat folds in one cycle later, in BUSY or DRAIN.
    if (sq_vld_q) begin
      acc_d    = sum[FW-1:0];
      ovf_d    = ovf_q | sum[FW];
      sq_vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (any_vld) begin
          state_d  = BUSY;
          gnt_d    = winner;
          acc_d    = '0;
          count_d  = '0;
          ovf_d    = 1'b0;
          sq_vld_d = 1'b0;
        end
      end
      BUSY: begin
        req_ready_c[gnt_q] = 1'b1;
        if (bus.req_valid[gnt_q]) begin
          sq_d     = a_ext * a_ext;
          sq_vld_d = 1'b1;
          count_d  = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          if (bus.req_last[gnt_q]) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (!out_vld_q) begin
          out_vld_d   = 1'b1;
          out_f_d     = acc_q;
          out_id_d    = gnt_q;
          out_count_d = count_q;
          out_ovf_d   = ovf_q;
        end else if (bus.out_ready) begin
          out_vld_d = 1'b0;
          ptr_d     = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      acc_q       <= '0;
      sq_q        <= '0;
      sq_vld_q    <= 1'b0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_vld_q   <= 1'b0;
      out_f_q     <= '0;
      out_id_q    <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      acc_q       <= acc_d;
      sq_q        <= sq_d;
      sq_vld_q    <= sq_vld_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_vld_q   <= out_vld_d;
      out_f_q     <= out_f_d;
      out_id_q    <= out_id_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.out_valid = out_vld_q;
  assign bus.out_f     = out_f_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule
